id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage CPU; sits directly upstream of the ALU (the chain of ALU bit-slices).
- Captures decoded operands and control each cycle.
- Resolves EX-stage operand forwarding from EX/MEM and MEM/WB.
- Drives the ALU's a, b, inv and op[1:0] inputs, detects load-use hazards, and inserts bubbles.

Parameters:
DATA_W, 32, datapath width (number of ALU slices)
REG_AW, 5, register-index width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
stall  in  1  external hold (e.g. memory wait); freezes stage contents
flush  in  1  branch/exception squash; loads a bubble
id_valid  in  1  decode stage holds a real instruction
id_rs_data  in  DATA_W  register-file read port A
id_rt_data  in  DATA_W  register-file read port B
id_imm  in  DATA_W  sign-extended immediate
id_rs  in  REG_AW  source index A
id_rt  in  REG_AW  source index B
id_rd  in  REG_AW  destination index, already muxed by decoder
id_uses_rt  in  1  instruction reads rt as a source
id_alu_src  in  1  1 selects id_imm as ALU b
id_alu_ctrl  in  3  {inv, op[1:0]}: 000 and, 001 or, 010 add, 110 sub, 111 slt
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control bits
exmem_reg_write  in  1  EX/MEM writes a register
exmem_rd  in  REG_AW  EX/MEM destination
exmem_result  in  DATA_W  EX/MEM ALU result
memwb_reg_write  in  1  MEM/WB writes a register
memwb_rd  in  REG_AW  MEM/WB destination
memwb_result  in  DATA_W  MEM/WB write-back value
hazard_stall  out  1  load-use hazard; IF/ID must hold
ex_valid  out  1  EX holds a real instruction
ex_a  out  DATA_W  forwarded ALU operand a
ex_b  out  DATA_W  ALU operand b (immediate or forwarded rt)
ex_inv  out  1  ALU b-invert / carry-in
ex_op  out  2  ALU output select
ex_store_data  out  DATA_W  forwarded rt value, for stores
ex_rd  out  REG_AW  destination index
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  registered control, gated by ex_valid

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - All registered fields clear to 0; ex_valid=0.
  - Outputs therefore read 0; hazard_stall=0.
  - Reset mid-stall or mid-hazard discards the held instruction.
- Per-edge update, priority highest first:
  - rst_n=0 → reset.
  - flush=1 → bubble.
  - stall=1 → hold all registers.
  - hazard_stall=1 → bubble.
  - Otherwise load all id_* fields, with ex_valid=id_valid.
- Bubble: ex_valid=0, and reg_write, mem_read, mem_write and alu_ctrl all cleared. Data fields need not be cleared.
- Latency: an ID value appears on ex_* one cycle after capture.
- hazard_stall (combinational): ex_valid & ex_mem_read & ex_rd!=0, and either ex_rd==id_rs or (id_uses_rt & ex_rd==id_rt). It is also gated by id_valid. A load followed by a dependent instruction yields exactly one bubble.
- Forwarding (combinational, computed on registered ex_rs/ex_rt):
  - Source a: exmem_reg_write & exmem_rd!=0 & exmem_rd==ex_rs → exmem_result.
  - Otherwise memwb_reg_write & memwb_rd!=0 & memwb_rd==ex_rs → memwb_result.
  - Otherwise the registered rs_data.
  - Source rt uses the same rule. EX/MEM always wins over MEM/WB.
  - Index 0 is never forwarded; its value comes from the register file (always 0).
- Operand b: ex_b = alu_src ? imm : forwarded rt. ex_store_data = forwarded rt regardless of alu_src.
- ALU control: {ex_inv, ex_op} = registered alu_ctrl. For slt, the top level wires less to slice 0 only.
- While held by stall, forwarding tracks the live exmem/memwb inputs every cycle.
- The stage is transparent to the ALU carry chain. inv is also the slice-0 carry-in.

Decomposition:
- Shared package/header: ALU control encodings (ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_SLT=3'b111), DATA_W, REG_AW.
- One natural sub-module, fwd_unit: a pure combinational forwarding select per operand, instanced twice (rs and rt).
- Hazard detection stays inline.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with id_valid=1 → ex_valid=0, ex_reg_write=0, ex_a=0, hazard_stall=0. Release, then load add rs=1 (0x5), rt=2 (0x7) → next cycle ex_a=0x5, ex_b=0x7, {ex_inv,ex_op}=010.
- Double forward: EX has rs=3; exmem_rd=3 (0xAAAA) and memwb_rd=3 (0x5555) both writing → ex_a=0xAAAA. Drop exmem_reg_write → ex_a=0x5555. Set exmem_rd=0 → no forward from it.
- Load-use: lw to r4 is in EX; ID presents sub with rs=4 → hazard_stall=1. Next edge gives ex_valid=0, mem_read=0. The following edge loads sub with hazard_stall=0. With id_uses_rt=0 and rt=4, hazard_stall stays 0.
- Stall/flush priority: stall=1 for 3 cycles → ex_* unchanged. Assert flush with stall → bubble loaded. Assert flush with hazard → single bubble.
- Immediate path: addi with id_imm=0xFFFFFFFC, alu_src=1, rt forwarded 0x1234 → ex_b=0xFFFFFFFC, ex_store_data=0x1234.
- slt: alu_ctrl=111 with rs=0x3, rt=0x9 → ex_inv=1, ex_op=11, operands passed unchanged.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// ============================================================================
// Module      : id_ex_stage_pkg
// Description : Shared widths and ALU control encodings for the ID/EX stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package id_ex_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  // {inv, op[1:0]} as seen by the ALU bit-slice chain
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_fwd_unit.sv
// ============================================================================
// Module      : fwd_unit
// Description : Combinational EX operand forwarding select (EX/MEM over MEM/WB).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_unit #(
  parameter int DATA_W = id_ex_stage_pkg::DATA_W,
  parameter int REG_AW = id_ex_stage_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic [DATA_W-1:0] i_reg_data,
  input  logic              i_exmem_reg_write,
  input  logic [REG_AW-1:0] i_exmem_rd,
  input  logic [DATA_W-1:0] i_exmem_result,
  input  logic              i_memwb_reg_write,
  input  logic [REG_AW-1:0] i_memwb_rd,
  input  logic [DATA_W-1:0] i_memwb_result,
  output logic [DATA_W-1:0] o_data
);

  // r0 is hard-wired zero, so a write "to" it must never be forwarded
  always_comb begin
    o_data = i_reg_data;
    if (i_exmem_reg_write && (i_exmem_rd != '0) && (i_exmem_rd == i_src)) begin
      o_data = i_exmem_result;
    end else if (i_memwb_reg_write && (i_memwb_rd != '0) && (i_memwb_rd == i_src)) begin
      o_data = i_memwb_result;
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with forwarding and load-use bubbling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = id_ex_stage_pkg::DATA_W,
  parameter int REG_AW = id_ex_stage_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rt,
  input  logic              id_alu_src,
  input  logic [2:0]        id_alu_ctrl,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic              ex_inv,
  output logic [1:0]        ex_op,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg
);

  logic              r_valid;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;
  logic              r_alu_src;
  logic [2:0]        r_alu_ctrl;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_mem_to_reg;

  logic              w_hazard;
  logic [DATA_W-1:0] w_fwd_a;
  logic [DATA_W-1:0] w_fwd_rt;

  // Load in EX whose destination is read by the instruction waiting in ID
  assign w_hazard = id_valid && r_valid && r_mem_read && (r_rd != '0) &&
                    ((r_rd == id_rs) || (id_uses_rt && (r_rd == id_rt)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_alu_src    <= 1'b0;
      r_alu_ctrl   <= ALU_AND;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (flush || (!stall && w_hazard)) begin
      r_valid     <= 1'b0;
      r_alu_ctrl  <= ALU_AND;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (!stall) begin
      r_valid      <= id_valid;
      r_rs_data    <= id_rs_data;
      r_rt_data    <= id_rt_data;
      r_imm        <= id_imm;
      r_rs         <= id_rs;
      r_rt         <= id_rt;
      r_rd         <= id_rd;
      r_alu_src    <= id_alu_src;
      r_alu_ctrl   <= id_alu_ctrl;
      r_reg_write  <= id_reg_write;
      r_mem_read   <= id_mem_read;
      r_mem_write  <= id_mem_write;
      r_mem_to_reg <= id_mem_to_reg;
    end
  end

  fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .i_src             (r_rs),
    .i_reg_data        (r_rs_data),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_result    (exmem_result),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_result    (memwb_result),
    .o_data            (w_fwd_a)
  );

  fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .i_src             (r_rt),
    .i_reg_data        (r_rt_data),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_result    (exmem_result),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_result    (memwb_result),
    .o_data            (w_fwd_rt)
  );

  assign hazard_stall  = w_hazard;
  assign ex_valid      = r_valid;
  assign ex_a          = w_fwd_a;
  assign ex_b          = r_alu_src ? r_imm : w_fwd_rt;
  assign ex_store_data = w_fwd_rt;
  assign ex_inv        = r_alu_ctrl[2];
  assign ex_op         = r_alu_ctrl[1:0];
  assign ex_rd         = r_rd;
  assign ex_reg_write  = r_valid & r_reg_write;
  assign ex_mem_read   = r_valid & r_mem_read;
  assign ex_mem_write  = r_valid & r_mem_write;
  assign ex_mem_to_reg = r_valid & r_mem_to_reg;

endmodule

`default_nettype wire
